// File: rtl/spi_byte_master.sv
// SPI mode-0 master: shifts one DATA_W-bit word out MSB first, framed by cs_n.
// Optional receive path (miso, rx_data) is enabled by defining SPI_RX_CAPTURE_EN.
module spi_byte_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
`ifdef SPI_RX_CAPTURE_EN
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [1:0]        dbg_state
);

  // Handshake: start is a request sampled only while busy=0; the edge that
  // samples it captures data_in, and busy stays high until the done cycle.
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              done_q, done_d;
`ifdef SPI_RX_CAPTURE_EN
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
`endif

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
`ifdef SPI_RX_CAPTURE_EN
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          tx_d    = data_in;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: present the next bit; zero fill leaves mosi low after the last bit.
            tx_d  = {tx_q[DATA_W-2:0], 1'b0};
            bit_d = bit_q + BIT_ONE;
            if (bit_q == BIT_LAST) state_d = HOLD;
          end
`ifdef SPI_RX_CAPTURE_EN
          else begin
            rx_d = {rx_q[DATA_W-2:0], miso};
          end
`endif
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = IDLE;
          div_d   = '0;
          done_d  = 1'b1;
`ifdef SPI_RX_CAPTURE_EN
          rx_data_d = rx_q;
`endif
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_RX_CAPTURE_EN
      rx_q      <= '0;
      rx_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
`ifdef SPI_RX_CAPTURE_EN
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign cs_n      = (state_q == IDLE);
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign mosi      = tx_q[DATA_W-1];
  assign dbg_state = state_q;
`ifdef SPI_RX_CAPTURE_EN
  assign rx_data = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: DATA_W=8 with CLK_DIV=4 and CLK_DIV=1 instances.
// Receive-path checks are compiled in when SPI_RX_CAPTURE_EN is defined.
module tb_spi_byte_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       busy0, done0, sclk0, mosi0, cs_n0;
  logic       busy1, done1, sclk1, mosi1, cs_n1;
  logic [1:0] st0, st1;
`ifdef SPI_RX_CAPTURE_EN
  logic [7:0] rx0, rx1;
`endif

  int errors = 0;
  int checks = 0;
  int rx_changes = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  spi_byte_master #(.DATA_W(8), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .start(start0), .data_in(data0),
`ifdef SPI_RX_CAPTURE_EN
    .miso(mosi0), .rx_data(rx0),
`endif
    .busy(busy0), .done(done0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0),
    .dbg_state(st0)
  );

  spi_byte_master #(.DATA_W(8), .CLK_DIV(1)) u_dut_fast (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
`ifdef SPI_RX_CAPTURE_EN
    .miso(mosi1), .rx_data(rx1),
`endif
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
    .dbg_state(st1)
  );

  logic m_sclk, m_mosi, m_done, m_cs_n;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_done = sel ? done1 : done0;
  assign m_cs_n = sel ? cs_n1 : cs_n0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after E0; returns #1 after the done edge (or after the cycle budget).
  task automatic run_frame(input bit noise, output logic [7:0] word, output int done_cyc,
                           output int first_rise, output int last_rise, output int rises,
                           output int bad);
    logic prev_sclk, prev_mosi;
`ifdef SPI_RX_CAPTURE_EN
    logic [7:0] rx_prev;
    rx_prev = sel ? rx1 : rx0;
`endif
    prev_sclk = m_sclk;
    prev_mosi = m_mosi;
    word = '0; done_cyc = -1; first_rise = -1; last_rise = -1; rises = 0; bad = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (m_sclk && !prev_sclk) begin
        word = {word[6:0], m_mosi};
        rises++;
        if (rises == 1) first_rise = n;
        last_rise = n;
      end
      if (m_mosi !== prev_mosi && !(prev_sclk && !m_sclk)) bad++;
      if (m_sclk && m_cs_n) bad++;
`ifdef SPI_RX_CAPTURE_EN
      if (!m_done && (sel ? rx1 : rx0) !== rx_prev) rx_changes++;
`endif
      prev_sclk = m_sclk;
      prev_mosi = m_mosi;
      if (m_done) begin
        done_cyc = n;
        break;
      end
      if (noise) begin
        data0  = 8'(n * 37);
        start0 = n[0];
      end
    end
  endtask

  task automatic check_frame(input string tag, input bit noise, input logic [7:0] exp_word,
                             input int cd);
    logic [7:0] word;
    int done_cyc, first_rise, last_rise, rises, bad;
    run_frame(noise, word, done_cyc, first_rise, last_rise, rises, bad);
    check({tag, "_word"}, 32'(word), 32'(exp_word));
    check({tag, "_done_cycle"}, done_cyc, 18 * cd);
    check({tag, "_rises"}, rises, 8);
    check({tag, "_first_rise"}, first_rise, 2 * cd);
    check({tag, "_last_rise"}, last_rise, 16 * cd);
    check({tag, "_mosi_sclk_rules"}, bad, 0);
    check({tag, "_end_cs_n"}, 32'(m_cs_n), 1);
    check({tag, "_end_mosi"}, 32'(m_mosi), 0);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int dones, selects;
    dones = 0; selects = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done0) dones++;
      if (!cs_n0) selects++;
    end
    check({tag, "_no_done"}, dones, 0);
    check({tag, "_no_select"}, selects, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_cs_n", 32'(cs_n0), 1);
    check("rst_busy", 32'(busy0), 0);
    check("rst_sclk_mosi_done", {sclk0, mosi0, done0}, 0);
    check("rst_state", 32'(st0), 0);
`ifdef SPI_RX_CAPTURE_EN
    check("rst_rx_data", 32'(rx0), 0);
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("idle_cs_n", 32'(cs_n0), 1);

    // Frame 0xA5 followed back-to-back by 0x3C.
    start0 = 1'b1; data0 = 8'hA5;
    tick();
    start0 = 1'b0;
    check("a5_e0_cs_n", 32'(cs_n0), 0);
    check("a5_e0_busy", 32'(busy0), 1);
    check("a5_e0_mosi", 32'(mosi0), 1);
    check("a5_e0_sclk", 32'(sclk0), 0);
    check_frame("a5", 1'b0, 8'hA5, 4);
    check("a5_done_busy", 32'(busy0), 0);
    start0 = 1'b1; data0 = 8'h3C;
    tick();
    start0 = 1'b0; data0 = 8'hFF;
    check("b2b_cs_n_low", 32'(cs_n0), 0);
    check("b2b_done_single", 32'(done0), 0);
    check("b2b_e0_mosi", 32'(mosi0), 0);
    check_frame("b2b_3c", 1'b0, 8'h3C, 4);
    tick();
    check("after_done_low", 32'(done0), 0);

    // Input noise during a frame must not disturb it or queue another.
    start0 = 1'b1; data0 = 8'h96;
    tick();
    check_frame("noise_96", 1'b1, 8'h96, 4);
    start0 = 1'b0;
    quiet_window("noise_after", 100);

    // Reset 30 cycles into a frame.
    start0 = 1'b1; data0 = 8'h5A;
    tick();
    start0 = 1'b0;
    repeat (30) tick();
    check("mid_busy_before_rst", 32'(busy0), 1);
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n0), 1);
    check("abort_sclk", 32'(sclk0), 0);
    check("abort_busy", 32'(busy0), 0);
    check("abort_done_mosi", {done0, mosi0}, 0);
    tick();
    rst = 1'b0;
    quiet_window("abort_after", 80);
    start0 = 1'b1; data0 = 8'hC3;
    tick();
    start0 = 1'b0;
    check_frame("fresh_c3", 1'b0, 8'hC3, 4);

    // CLK_DIV=1 instance with an all-ones word.
    sel = 1'b1;
    start1 = 1'b1; data1 = 8'hFF;
    tick();
    start1 = 1'b0;
    check("fast_e0_mosi", 32'(mosi1), 1);
    check_frame("fast_ff", 1'b0, 8'hFF, 1);
    sel = 1'b0;

`ifdef SPI_RX_CAPTURE_EN
    tick();
    start0 = 1'b1; data0 = 8'h81;
    tick();
    start0 = 1'b0;
    check_frame("rx_81", 1'b0, 8'h81, 4);
    check("rx_data_81", 32'(rx0), 32'h81);
    rx_changes = 0;
    repeat (5) tick();
    start0 = 1'b1; data0 = 8'h42;
    tick();
    start0 = 1'b0;
    check("rx_hold_start", 32'(rx0), 32'h81);
    check_frame("rx_42", 1'b0, 8'h42, 4);
    check("rx_hold_changes", rx_changes, 0);
    check("rx_data_42", 32'(rx0), 32'h42);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
SPI_BYTE_MASTER -- requirements
Module: spi_byte_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits (≥2).
REQ-002 SHALL have parameter CLK_DIV, default 4, SCLK half-period in clk cycles (≥1).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  transfer request, sampled only when busy=0.
REQ-006 SHALL have port data_in  input  DATA_W  parallel word to transmit, typically a counter value.
REQ-007 SHALL have port busy  output  1  high from the cycle after start acceptance through the HOLD state.
REQ-008 SHALL have port done  output  1  single-cycle pulse at end of frame.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 SHALL have port mosi  output  1  serial data, MSB first.
REQ-011 SHALL have port cs_n  output  1  chip select, active-low.
REQ-012 SHALL have ports miso (input, 1) and rx_data (output, DATA_W) only when SPI_RX_CAPTURE_EN is defined.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD; transitions IDLE->SETUP on start, SETUP->SHIFT after CLK_DIV cycles, SHIFT->HOLD after DATA_W-th falling sclk edge, HOLD->IDLE after CLK_DIV cycles.
REQ-014 SHALL, at edge E0 sampling start=1 in IDLE, latch data_in, drive cs_n=0, mosi=data_in[DATA_W-1], busy=1.
REQ-015 SHALL ignore data_in changes after E0 and start while busy=1.
REQ-016 SHALL in SHIFT toggle sclk every CLK_DIV clk cycles, producing exactly DATA_W rising and DATA_W falling edges, 50% duty.
REQ-017 SHALL change mosi only on the clk edge that drives sclk low (next bit), holding it stable across each sclk rising edge.
REQ-018 SHALL keep sclk=0 in IDLE, SETUP, HOLD.
REQ-019 SHALL, at edge E0+(2*DATA_W+2)*CLK_DIV, drive cs_n=1, busy=0, done=1 for exactly one cycle, mosi=0, state IDLE.
REQ-020 SHALL accept start during the done cycle (back-to-back), giving cs_n high for exactly one clk cycle between frames.
REQ-021 SHALL use a bit counter of width clog2(DATA_W)+1 and a divider counter of width clog2(CLK_DIV)+1; neither wraps during a frame.

Reset
REQ-022 SHALL on rst=1 immediately force state IDLE, busy=0, done=0, sclk=0, mosi=0, cs_n=1, counters 0, rx_data=0 (when present).
REQ-023 SHALL abort any frame on rst mid-transfer with no done pulse; first start after rst release begins a fresh frame.

Configuration
REQ-024 SHALL, when SPI_RX_CAPTURE_EN is defined, sample miso on each clk edge driving sclk high, shift MSB-first into a receive register, and load rx_data at the done edge, holding it otherwise.
REQ-025 SHALL, when SPI_RX_CAPTURE_EN is undefined, omit miso, rx_data and the receive register; transmit behaviour identical.

Verification
REQ-026 SHALL verify DATA_W=8, CLK_DIV=4, data_in=0xA5, start pulse -> mosi bits 1,0,1,0,0,1,0,1 at 8 sclk rising edges, done exactly 72 cycles after E0.
REQ-027 SHALL verify start asserted again during done with data_in=0x3C -> cs_n high exactly 1 cycle, second frame carries 0x3C.
REQ-028 SHALL verify start pulses while busy and data_in toggling during frame -> single frame, transmitted word = value at E0.
REQ-029 SHALL verify rst asserted at cycle 30 of frame -> cs_n=1, sclk=0, busy=0 same cycle, no done pulse.
REQ-030 SHALL verify with SPI_RX_CAPTURE_EN, miso looped to mosi, data_in=0x81 -> rx_data=0x81 at done, unchanged until next done.
REQ-031 SHALL verify CLK_DIV=1, data_in=0xFF -> sclk period 2 clk cycles, done at E0+18.
